// File: rtl/write_bram_pkg.sv
// Shared constants for the write_bram slice: input FIFO geometry.
package write_bram_pkg;

    localparam int FIFO_NUM_SLOTS     = 4;
    localparam int FIFO_LOG_NUM_SLOTS = 2;

endpackage : write_bram_pkg

// File: rtl/write_bram_fifo.sv
// Small power-of-two FIFO with first-word-fall-through head output.
// Handshake: a push is accepted when not full, or when full and popping in
// the same cycle; a pop is accepted when not empty. A push that arrives while
// full without a pop is dropped (upstream broke the avail contract).
module write_bram_fifo #(
    parameter int NUM_SLOTS     = 4,
    parameter int LOG_NUM_SLOTS = 2,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full
);

    localparam logic [LOG_NUM_SLOTS:0]   CNT_ONE  = (LOG_NUM_SLOTS+1)'(1);
    localparam logic [LOG_NUM_SLOTS:0]   CNT_FULL = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
    localparam logic [LOG_NUM_SLOTS:0]   CNT_AF   = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);
    localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE  = LOG_NUM_SLOTS'(1);

    logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wr_ptr;
    logic [LOG_NUM_SLOTS-1:0] rd_ptr;
    logic [LOG_NUM_SLOTS:0]   count;
    logic                     do_push;
    logic                     do_pop;

    assign empty       = (count == '0);
    assign full        = (count == CNT_FULL);
    assign almost_full = (count >= CNT_AF);
    assign do_pop      = pop & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign head        = mem[rd_ptr];

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at NUM_SLOTS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule : write_bram_fifo

// File: rtl/write_bram.sv
// Buffers an upstream stream in a 4-slot FIFO and drains it into a block ram
// port, num_iters passes over num_writes_per_iter addresses from base_address.
// Handshake: upstream may raise valid_in only in a cycle where avail_out=1;
// the word is captured at that clock edge. The bram side has no back-pressure:
// write_out/address_out/data_out are a registered one-cycle write strobe.
module write_bram
    import write_bram_pkg::*;
#(
    parameter int    DATA_WIDTH              = 8,
    parameter int    LOG_MAX_ITERS           = 16,
    parameter int    LOG_MAX_WRITES_PER_ITER = 16,
    parameter int    LOG_MAX_ADDRESS         = 16,
    parameter string TYPE                    = "unspecified"
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               configure,
    input  logic [LOG_MAX_ITERS-1:0]           num_iters,
    input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
    input  logic                               valid_in,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               avail_out,
    output logic                               write_out,
    output logic [LOG_MAX_ADDRESS-1:0]         address_out,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               done
);

    localparam logic [LOG_MAX_ITERS-1:0]           ITER_ONE  = LOG_MAX_ITERS'(1);
    localparam logic [LOG_MAX_WRITES_PER_ITER-1:0] WRITE_ONE = LOG_MAX_WRITES_PER_ITER'(1);
    localparam logic [LOG_MAX_ADDRESS-1:0]         ADDR_ONE  = LOG_MAX_ADDRESS'(1);

    logic                               enabled_r;
    logic [LOG_MAX_ITERS-1:0]           iters_r;
    logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_r;
    logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_copy_r;
    logic [LOG_MAX_ADDRESS-1:0]         addr_r;
    logic [LOG_MAX_ADDRESS-1:0]         base_copy_r;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_almost_full;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  pop;

    // Keep one slot of slack so an upstream that reacts a cycle late is safe.
    assign avail_out = ~fifo_full & ~fifo_almost_full;
    // A configure cycle never writes, so the new counters apply to the next pop.
    assign pop       = enabled_r & ~fifo_empty & ~configure;

    write_bram_fifo #(
        .NUM_SLOTS     (FIFO_NUM_SLOTS),
        .LOG_NUM_SLOTS (FIFO_LOG_NUM_SLOTS),
        .DATA_WIDTH    (DATA_WIDTH)
    ) fifo_in (
        .clk         (clk),
        .rst         (rst),
        .push        (valid_in),
        .pop         (pop),
        .data_in     (data_in),
        .head        (fifo_head),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .almost_full (fifo_almost_full)
    );

    // Configuration load, address/iteration counters and the bram output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enabled_r     <= 1'b0;
            iters_r       <= '0;
            writes_r      <= '0;
            writes_copy_r <= '0;
            addr_r        <= '0;
            base_copy_r   <= '0;
            write_out     <= 1'b0;
            address_out   <= '0;
            data_out      <= '0;
            done          <= 1'b0;
        end else begin
            write_out <= 1'b0;
            done      <= 1'b0;
            if (configure) begin
                iters_r       <= num_iters;
                writes_r      <= num_writes_per_iter;
                writes_copy_r <= num_writes_per_iter;
                addr_r        <= base_address;
                base_copy_r   <= base_address;
                // An empty pattern finishes immediately without enabling.
                if ((num_iters == '0) || (num_writes_per_iter == '0)) begin
                    enabled_r <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    enabled_r <= 1'b1;
                end
            end else if (pop) begin
                write_out   <= 1'b1;
                address_out <= addr_r;
                data_out    <= fifo_head;
                if (writes_r == WRITE_ONE) begin
                    if (iters_r == ITER_ONE) begin
                        enabled_r <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        iters_r  <= iters_r - ITER_ONE;
                        writes_r <= writes_copy_r;
                        addr_r   <= base_copy_r;
                    end
                end else begin
                    writes_r <= writes_r - WRITE_ONE;
                    addr_r   <= addr_r + ADDR_ONE;
                end
            end
        end
    end

endmodule : write_bram

// File: tb/tb_write_bram.sv
// Directed bench for write_bram: each scenario pushes words, a negedge monitor
// records every bram write, and the recorded stream is compared to hand-built
// expected queues.
module tb_write_bram;

    localparam int DW = 8;
    localparam int LA = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          configure = 1'b0;
    logic [15:0]   num_iters = '0;
    logic [15:0]   num_writes_per_iter = '0;
    logic [LA-1:0] base_address = '0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          avail_out;
    logic          write_out;
    logic [LA-1:0] address_out;
    logic [DW-1:0] data_out;
    logic          done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [LA-1:0] got_addr_q[$];
    logic [DW-1:0] got_data_q[$];
    logic          got_done_q[$];
    int            got_cyc_q[$];
    logic [LA-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_done_q[$];

    write_bram dut (
        .clk                 (clk),
        .rst                 (rst),
        .configure           (configure),
        .num_iters           (num_iters),
        .num_writes_per_iter (num_writes_per_iter),
        .base_address        (base_address),
        .valid_in            (valid_in),
        .data_in             (data_in),
        .avail_out           (avail_out),
        .write_out           (write_out),
        .address_out         (address_out),
        .data_out            (data_out),
        .done                (done)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor: sample outputs mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (write_out) begin
            got_addr_q.push_back(address_out);
            got_data_q.push_back(data_out);
            got_done_q.push_back(done);
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [LA-1:0] base, input logic [15:0] it, input logic [15:0] wr);
        configure = 1'b1;
        base_address = base;
        num_iters = it;
        num_writes_per_iter = wr;
        tick(1);
        configure = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        valid_in = 1'b1;
        data_in = d;
        tick(1);
        valid_in = 1'b0;
    endtask

    task automatic clear_sb();
        got_addr_q.delete();
        got_data_q.delete();
        got_done_q.delete();
        got_cyc_q.delete();
        exp_addr_q.delete();
        exp_q.delete();
        exp_done_q.delete();
        done_cnt = 0;
    endtask

    task automatic expect_write(input logic [LA-1:0] a, input logic [DW-1:0] d, input logic dn);
        exp_addr_q.push_back(a);
        exp_q.push_back(d);
        exp_done_q.push_back(dn);
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_count"}, got_addr_q.size(), exp_addr_q.size());
        n = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr_q[i], exp_addr_q[i]);
            check($sformatf("%s_data%0d", tag, i), got_data_q[i], exp_q[i]);
            check($sformatf("%s_done%0d", tag, i), got_done_q[i], exp_done_q[i]);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_write", write_out, 0);
        check("rst_addr", address_out, 0);
        check("rst_data", data_out, 0);
        check("rst_done", done, 0);
        check("rst_avail", avail_out, 1);
        rst = 1'b1;
        tick(1);

        // Basic pass with latency check
        clear_sb();
        cfg(16'h0010, 1, 4);
        push_word(8'hA1);
        check("lat_early", write_out, 0);
        push_word(8'hA2);
        check("lat_write", write_out, 1);
        check("lat_addr", address_out, 16'h0010);
        check("lat_data", data_out, 8'hA1);
        push_word(8'hA3);
        push_word(8'hA4);
        tick(4);
        expect_write(16'h0010, 8'hA1, 0);
        expect_write(16'h0011, 8'hA2, 0);
        expect_write(16'h0012, 8'hA3, 0);
        expect_write(16'h0013, 8'hA4, 1);
        check_stream("basic");
        check("basic_done_cnt", done_cnt, 1);
        if (got_cyc_q.size() == 4) check("basic_consec", got_cyc_q[3] - got_cyc_q[0], 3);
        else check("basic_consec_n", got_cyc_q.size(), 4);

        // Iterations
        clear_sb();
        cfg(16'h0020, 3, 2);
        for (int i = 0; i < 6; i++) push_word(8'hB0 + 8'(i));
        tick(4);
        for (int i = 0; i < 6; i++) expect_write(16'h0020 + 16'(i % 2), 8'hB0 + 8'(i), i == 5);
        check_stream("iter");
        check("iter_done_cnt", done_cnt, 1);

        // Back-pressure while disabled
        clear_sb();
        push_word(8'hC0);
        check("bp_avail1", avail_out, 1);
        push_word(8'hC1);
        check("bp_avail2", avail_out, 1);
        push_word(8'hC2);
        check("bp_avail3", avail_out, 0);
        tick(2);
        check("bp_idle_writes", got_addr_q.size(), 0);
        cfg(16'h0040, 1, 3);
        check("bp_cfg_nowrite", write_out, 0);
        tick(5);
        expect_write(16'h0040, 8'hC0, 0);
        expect_write(16'h0041, 8'hC1, 0);
        expect_write(16'h0042, 8'hC2, 1);
        check_stream("bp");
        check("bp_avail_back", avail_out, 1);

        // Address wrap
        clear_sb();
        cfg(16'hFFFE, 1, 4);
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        tick(4);
        expect_write(16'hFFFE, 8'h11, 0);
        expect_write(16'hFFFF, 8'h12, 0);
        expect_write(16'h0000, 8'h13, 0);
        expect_write(16'h0001, 8'h14, 1);
        check_stream("wrap");

        // Zero-length configure
        clear_sb();
        cfg(16'h0050, 2, 0);
        check("zero_done", done, 1);
        check("zero_write", write_out, 0);
        tick(1);
        check("zero_done_pulse", done, 0);
        tick(3);
        check("zero_writes", got_addr_q.size(), 0);
        check("zero_done_cnt", done_cnt, 1);

        // Reconfigure mid-stream after two writes
        clear_sb();
        cfg(16'h0060, 1, 5);
        push_word(8'hE0);
        push_word(8'hE1);
        push_word(8'hE2);
        configure = 1'b1;
        base_address = 16'h0070;
        num_iters = 1;
        num_writes_per_iter = 3;
        push_word(8'hE3);
        configure = 1'b0;
        push_word(8'hE4);
        tick(5);
        expect_write(16'h0060, 8'hE0, 0);
        expect_write(16'h0061, 8'hE1, 0);
        expect_write(16'h0070, 8'hE2, 0);
        expect_write(16'h0071, 8'hE3, 0);
        expect_write(16'h0072, 8'hE4, 1);
        check_stream("reconf");
        check("reconf_done_cnt", done_cnt, 1);

        // Asynchronous reset during a burst
        cfg(16'h0080, 1, 4);
        push_word(8'hF0);
        push_word(8'hF1);
        valid_in = 1'b1;
        data_in = 8'hF2;
        @(posedge clk);
        #3;
        valid_in = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_write", write_out, 0);
        check("arst_addr", address_out, 0);
        check("arst_data", data_out, 0);
        check("arst_done", done, 0);
        clear_sb();
        tick(2);
        rst = 1'b1;
        push_word(8'h77);
        tick(4);
        check("arst_no_writes", got_addr_q.size(), 0);
        cfg(16'h0090, 1, 1);
        tick(3);
        expect_write(16'h0090, 8'h77, 1);
        check_stream("arst_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_write_bram

// File: doc/write_bram.md
Name: write_bram

Overview:
- Counterpart of the bram read module.
- Accepts a data stream from an upstream module through an avail/valid handshake and buffers it in a 4-slot FIFO.
- Drains the FIFO into a block ram, one write per cycle, with a configurable address pattern: num_iters passes over num_writes_per_iter consecutive addresses starting at base_address.
- Sits between a compute or forward stage and the bram write port.

Parameters:
- DATA_WIDTH, 8, data width of the stream and the bram word.
- LOG_MAX_ITERS, 16, bits of the iteration counter.
- LOG_MAX_WRITES_PER_ITER, 16, bits of the writes-per-iteration counter.
- LOG_MAX_ADDRESS, 16, bram address width.
- TYPE, "unspecified", label used only in debug prints.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- configure  in  1  CONFIGURE: load the three fields below and enable the module.
- num_iters  in  LOG_MAX_ITERS  CONFIGURE: number of iterations.
- num_writes_per_iter  in  LOG_MAX_WRITES_PER_ITER  CONFIGURE: writes per iteration.
- base_address  in  LOG_MAX_ADDRESS  CONFIGURE: first bram address of each iteration.
- valid_in  in  1  IN: upstream data valid.
- data_in  in  DATA_WIDTH  IN: upstream data.
- avail_out  out  1  IN: block can accept data this cycle.
- write_out  out  1  OUT: bram write enable (registered).
- address_out  out  LOG_MAX_ADDRESS  OUT: bram address (registered).
- data_out  out  DATA_WIDTH  OUT: bram write data (registered).
- done  out  1  one-cycle pulse when the last configured write is issued.

Behaviour:
- Reset (rst=0, async):
  - write_out, address_out, data_out and done all go to 0.
  - All counters go to 0, the module is disabled and the FIFO is emptied.
  - Reset mid-operation aborts immediately; no further writes are issued.
- avail_out = ~full & ~almost_full. This is combinational from the FIFO flags; almost_full means count >= 3.
- Push rules:
  - valid_in pushes data_in into the FIFO the same cycle.
  - Upstream asserts valid_in only when it samples avail_out=1 in that cycle.
  - valid_in while full is a protocol violation: the push is ignored, the data is lost and a debug message is printed.
- Pop condition is pop = module_enabled_r & ~empty & ~configure.
- On each pop, at the next clock edge:
  - write_out=1, address_out=addr_r, data_out=FIFO head.
  - Latency from a push into an empty FIFO of an enabled block to write_out is 2 cycles: one for FIFO registration, one for the output register.
- On cycles without a pop, write_out=0 while address_out and data_out hold their last values.
- Counter update on each pop:
  - If writes_r==1 and iters_r==1: disable the module and set done=1 on the same edge that sets the final write_out.
  - If writes_r==1 and iters_r>1: decrement iters_r, reload writes_r from its copy and addr_r from the base copy.
  - Otherwise: decrement writes_r and increment addr_r, wrapping modulo 2^LOG_MAX_ADDRESS (e.g. 0xFFFF+1 = 0x0000).
- configure has priority over pop:
  - It loads iters_r, writes_r, addr_r and their copies, and sets enabled.
  - No pop occurs in that cycle; write_out=0 next cycle.
  - Configure mid-operation discards the remaining count but keeps the FIFO contents, which are written under the new configuration.
- Configure with num_iters==0 or num_writes_per_iter==0: the module stays disabled, done pulses on the next cycle, and nothing is written.
- While disabled, pushes are still accepted until the FIFO is full; the data stays buffered until the next configure.
- Simultaneous push and pop: allowed, including when the FIFO is full; the occupancy is unchanged.
- Sustained throughput is 1 write/cycle while upstream keeps valid_in high.

Decomposition:
- Constants and debug defines belong in the shared RTLinf.vh header; the block adds no new typedefs.
- One sub-module: the existing FIFO, with NUM_SLOTS=4, LOG_NUM_SLOTS=2 and DATA_WIDTH, instantiated as fifo_in.
- Counters and output registers live in the top module.

Test Plan:
- Basic pass: configure base=0x10, iters=1, writes=4; push 0xA1..0xA4 on consecutive cycles -> write_out high for 4 consecutive cycles, addresses 0x10..0x13, data 0xA1..0xA4, done coincident with the 0x13 write.
- Iterations: base=0x20, iters=3, writes=2; push 6 words -> addresses 0x20,0x21,0x20,0x21,0x20,0x21 in order; one done pulse.
- Back-pressure: block disabled; push 3 words -> avail_out drops to 0 after the 3rd push; configure iters=1, writes=3 -> 3 writes issued and avail_out returns to 1.
- Wrap: base=0xFFFE, writes=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- Boundaries: configure with writes=0 -> done pulse next cycle, write_out stays 0. Reconfigure mid-stream after 2 of 5 writes -> FIFO remainder is written from the new base.
- Async reset: assert rst=0 between clock edges during a burst -> all outputs 0 immediately, no write_out after reset release until configure.
